naf_udp_main: RTL and testbench

//   Store-and-forward UDP payload echo engine; top-level core of the NAF network function.

---
 rtl/naf_pkg.sv | 16 +
 rtl/naf_byte_ram.sv | 29 ++
 rtl/naf_udp_main.sv | 167 ++++++++++++++++
 tb/tb_naf_udp_main.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/naf_pkg.sv
// Shared types for the NAF UDP payload echo core.
// Buffer sizing default, byte type and receive/send state encoding.
package naf_pkg;

  localparam int DEF_BUF_DEPTH = 2048;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    RECV_IDLE,
    RECV,
    DROP,
    SEND
  } state_t;

endpackage

// File: rtl/naf_byte_ram.sv
// Simple dual-port payload buffer: one write port, one registered read port.
// Contents are not reset; only bytes written by the current packet are read.
module naf_byte_ram
  import naf_pkg::*;
#(
  parameter int DEPTH = DEF_BUF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  byte_t         wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output byte_t         rd_data
);

  byte_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/naf_udp_main.sv
// Store-and-forward UDP payload echo: buffer one datagram, replay it on TX.
// Read path is RAM data stage plus output register, refilled on every TX accept.
module naf_udp_main
  import naf_pkg::*;
#(
  parameter int BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int ADDR_W    = $clog2(BUF_DEPTH)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       udp_rx_valid,
  output logic       udp_rx_ready,
  input  logic       udp_rx_first,
  input  logic       udp_rx_last,
  input  logic [7:0] udp_rx_payload,
  input  logic       udp_rx_last_be,
  output logic       udp_tx_valid,
  input  logic       udp_tx_ready,
  output logic       udp_tx_first,
  output logic       udp_tx_last,
  output logic [7:0] udp_tx_payload
);

  localparam int LW = ADDR_W + 1;
  localparam logic [LW-1:0] FULL = LW'(BUF_DEPTH);
  localparam logic [LW-1:0] ONE  = LW'(1);

  state_t state, state_nx;

  logic [LW-1:0]     wr_len, wr_len_nx;
  logic [LW-1:0]     rd_ptr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_en;
  byte_t             rd_data;
  logic              rd_vld;
  logic              rd_first;
  logic              rd_last;
  logic              out_load;
  logic              rx_hs;
  logic              tx_hs;
  logic              unused_last_be;

  // the bus is one byte wide, so the last-beat byte enable is meaningless
  assign unused_last_be = udp_rx_last_be;

  assign udp_rx_ready = (state != SEND);
  assign rx_hs = udp_rx_valid & udp_rx_ready & enable;
  assign tx_hs = udp_tx_valid & udp_tx_ready & enable;

  // data stage drains into the output register whenever that slot frees up
  assign out_load = rd_vld & (~udp_tx_valid | udp_tx_ready);
  assign rd_en = (state == SEND) & (rd_ptr != wr_len)
               & (~rd_vld | out_load);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RECV_IDLE;
    end else if (enable) begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    wr_len_nx = wr_len;
    wr_en     = 1'b0;
    wr_addr   = wr_len[ADDR_W-1:0];
    unique case (state)
      RECV_IDLE: begin
        if (rx_hs && udp_rx_first) begin
          wr_en     = 1'b1;
          wr_addr   = '0;
          wr_len_nx = ONE;
          state_nx  = udp_rx_last ? SEND : RECV;
        end
      end
      RECV: begin
        if (rx_hs) begin
          if (udp_rx_first) begin
            wr_en     = 1'b1;
            wr_addr   = '0;
            wr_len_nx = ONE;
            state_nx  = udp_rx_last ? SEND : RECV;
          end else if (wr_len == FULL) begin
            wr_len_nx = '0;
            state_nx  = udp_rx_last ? RECV_IDLE : DROP;
          end else begin
            wr_en     = 1'b1;
            wr_len_nx = wr_len + ONE;
            if (udp_rx_last) begin
              state_nx = SEND;
            end
          end
        end
      end
      DROP: begin
        if (rx_hs && udp_rx_last) begin
          state_nx = RECV_IDLE;
        end
      end
      SEND: begin
        if (tx_hs && udp_tx_last) begin
          wr_len_nx = '0;
          state_nx  = RECV_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_len   <= '0;
      rd_ptr   <= '0;
      rd_vld   <= 1'b0;
      rd_first <= 1'b0;
      rd_last  <= 1'b0;
    end else if (enable) begin
      wr_len <= wr_len_nx;
      if (tx_hs && udp_tx_last) begin
        rd_ptr <= '0;
      end else if (rd_en) begin
        rd_ptr <= rd_ptr + ONE;
      end
      if (rd_en) begin
        rd_vld   <= 1'b1;
        rd_first <= (rd_ptr == '0);
        rd_last  <= (rd_ptr == wr_len - ONE);
      end else if (out_load) begin
        rd_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      udp_tx_valid   <= 1'b0;
      udp_tx_first   <= 1'b0;
      udp_tx_last    <= 1'b0;
      udp_tx_payload <= 8'h00;
    end else if (enable) begin
      if (out_load) begin
        udp_tx_valid   <= 1'b1;
        udp_tx_first   <= rd_first;
        udp_tx_last    <= rd_last;
        udp_tx_payload <= rd_data;
      end else if (tx_hs) begin
        udp_tx_valid <= 1'b0;
      end
    end
  end

  naf_byte_ram #(
    .DEPTH (BUF_DEPTH),
    .AW    (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en & enable),
    .wr_addr (wr_addr),
    .wr_data (udp_rx_payload),
    .rd_en   (rd_en & enable),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_naf_udp_main.sv
// Scoreboard bench for naf_udp_main: directed packets, monitor checks TX beats.
module tb_naf_udp_main;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_first;
  logic       rx_last;
  logic [7:0] rx_payload;
  logic       rx_last_be;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_first;
  logic       tx_last;
  logic [7:0] tx_payload;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_hs = 0;
  int tx_seen = 0;
  int ready_mode = 0;
  logic [9:0] sb[$];
  logic [7:0] pkt[$];

  naf_udp_main dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .udp_rx_valid   (rx_valid),
    .udp_rx_ready   (rx_ready),
    .udp_rx_first   (rx_first),
    .udp_rx_last    (rx_last),
    .udp_rx_payload (rx_payload),
    .udp_rx_last_be (rx_last_be),
    .udp_tx_valid   (tx_valid),
    .udp_tx_ready   (tx_ready),
    .udp_tx_first   (tx_first),
    .udp_tx_last    (tx_last),
    .udp_tx_payload (tx_payload)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (enable) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (ready_mode == 1) tx_ready = ~tx_ready;
      else tx_ready = 1'b1;
    end
  end

  logic       pv = 1'b0;
  logic       pstall = 1'b0;
  logic [9:0] psave = '0;

  always @(negedge clock) begin
    logic [9:0] got;
    logic [9:0] exp;
    got = {tx_first, tx_last, tx_payload};
    if (reset) begin
      pv = 1'b0;
      pstall = 1'b0;
    end else if (enable) begin
      if (pstall) chk("stall_hold", {tx_valid, got}, {1'b1, psave});
      if (tx_valid) chk("rx_blocked", rx_ready, 0);
      if (tx_valid && !pv) chk("latency", cyc - last_hs, 3);
      if (rx_valid && rx_ready && rx_last) last_hs = cyc;
      if (tx_valid && tx_ready) begin
        tx_seen++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_tx: got %0h expected none", got);
        end else begin
          exp = sb.pop_front();
          chk("tx_beat", got, exp);
        end
      end
      pv = tx_valid;
      pstall = tx_valid && !tx_ready;
      psave = got;
    end
  end

  task automatic beat(input logic [7:0] d, input logic f, input logic l);
    int t = 0;
    logic done = 1'b0;
    rx_valid = 1'b1;
    rx_payload = d;
    rx_first = f;
    rx_last = l;
    while (!done) begin
      @(negedge clock);
      if (rx_ready && enable && !reset) begin
        done = 1'b1;
      end else if (++t > 20000) begin
        total++;
        bad++;
        $display("FAIL rx_timeout: got no ready expected ready");
        done = 1'b1;
      end
      @(posedge clock);
      #1;
    end
    rx_valid = 1'b0;
    rx_first = 1'b0;
    rx_last = 1'b0;
  endtask

  task automatic send_pkt(input bit echo);
    int n = pkt.size();
    if (echo) begin
      for (int i = 0; i < n; i++)
        sb.push_back({i == 0, i == n - 1, pkt[i]});
    end
    for (int i = 0; i < n; i++) beat(pkt[i], i == 0, i == n - 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb.size() != 0 || tx_valid) && t < 20000) begin
      @(posedge clock);
      #1;
      t++;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  task automatic fill(input int n, input int base);
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(8'(base + i));
  endtask

  initial begin
    logic [10:0] snap;
    int t;
    int base;
    reset = 1'b1;
    enable = 1'b1;
    rx_valid = 1'b0;
    rx_first = 1'b0;
    rx_last = 1'b0;
    rx_payload = 8'h00;
    rx_last_be = 1'b1;
    #12;
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_first", tx_first, 0);
    chk("rst_tx_last", tx_last, 0);
    chk("rst_tx_payload", tx_payload, 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    pkt = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_pkt(1);
    wait_drain();

    pkt = '{8'h5A};
    send_pkt(1);
    wait_drain();

    ready_mode = 1;
    fill(16, 0);
    send_pkt(1);
    wait_drain();
    ready_mode = 0;

    fill(2049, 0);
    send_pkt(0);
    idle(10);
    pkt = '{8'h01, 8'h02, 8'h03};
    send_pkt(1);
    wait_drain();
    fill(2048, 8'h40);
    send_pkt(1);
    wait_drain();

    beat(8'h11, 1'b0, 1'b0);
    beat(8'h22, 1'b0, 1'b1);
    beat(8'hAA, 1'b1, 1'b0);
    beat(8'hBB, 1'b0, 1'b0);
    sb.push_back({1'b1, 1'b0, 8'hCC});
    sb.push_back({1'b0, 1'b1, 8'hDD});
    beat(8'hCC, 1'b1, 1'b0);
    beat(8'hDD, 1'b0, 1'b1);
    wait_drain();

    base = tx_seen;
    fill(8, 8'h10);
    send_pkt(1);
    t = 0;
    while (tx_seen < base + 2 && t < 1000) begin
      @(posedge clock);
      #1;
      t++;
    end
    chk("pre_reset_seen", tx_seen - base, 2);
    reset = 1'b1;
    #1;
    sb.delete();
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_rx_ready", rx_ready, 1);
    chk("mid_rst_tx_payload", tx_payload, 0);
    @(negedge clock);
    reset = 1'b0;
    idle(10);
    pkt = '{8'h7E, 8'h7F};
    send_pkt(1);
    wait_drain();

    base = tx_seen;
    fill(6, 8'hA0);
    send_pkt(1);
    t = 0;
    while (tx_seen < base + 2 && t < 1000) begin
      @(posedge clock);
      #1;
      t++;
    end
    enable = 1'b0;
    snap = {tx_valid, tx_first, tx_last, tx_payload};
    chk("frz_start_valid", tx_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      chk("frz_tx", {tx_valid, tx_first, tx_last, tx_payload}, snap);
      chk("frz_rx_ready", rx_ready, 0);
    end
    enable = 1'b1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
